// File: rtl/ym2413_env_seq.sv
// ym2413_env_seq: slot sequencer holding per-slot envelope, EG state and key history for a YM2413-style envelope generator
// Ports: clk, rst_n (async active-low); slot_en strobe processes the current slot and advances.
//   From calculator: ch_key_on, env_next, eg_state_next, op_phase_reset.
//   To calculator (same cycle): ch_sel, op_type, env_prev, eg_state_prev, key_off_on_trig, in_counter.
//   Result (registered): env_out, env_slot, phase_rst_out qualified by env_valid.
module ym2413_env_seq #(
  parameter int NUM_SLOTS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slot_en,
  input  logic       ch_key_on,
  input  logic [6:0] env_next,
  input  logic [1:0] eg_state_next,
  input  logic       op_phase_reset,
  output logic [3:0] ch_sel,
  output logic       op_type,
  output logic [6:0] env_prev,
  output logic [1:0] eg_state_prev,
  output logic [15:0] in_counter,
  output logic       key_off_on_trig,
  output logic [6:0] env_out,
  output logic [4:0] env_slot,
  output logic       env_valid,
  output logic       phase_rst_out
);
  logic [4:0]           slot_idx_q, slot_idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [6:0]           env_q [NUM_SLOTS];
  logic [1:0]           eg_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] key_q;
  logic                 key_cur, slot_last;
  logic [6:0]           env_out_q;
  logic [4:0]           env_slot_q;
  logic                 env_valid_q, phase_rst_q;

  // zero-latency read so the external calculator closes its loop in one cycle
  always_comb begin
    env_prev = 7'h7F;
    eg_state_prev = 2'b00;
    key_cur = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_idx_q == 5'(i)) begin
        env_prev = env_q[i];
        eg_state_prev = eg_q[i];
        key_cur = key_q[i];
      end
  end

  assign slot_last = slot_idx_q == 5'(NUM_SLOTS - 1);
  assign slot_idx_d = slot_en ? (slot_last ? 5'd0 : slot_idx_q + 5'd1) : slot_idx_q;
  // counter steps once per full pass over all slots
  assign cnt_d = (slot_en && slot_last) ? cnt_q + 16'd1 : cnt_q;

  assign ch_sel = slot_idx_q[4:1];
  assign op_type = slot_idx_q[0];
  assign key_off_on_trig = ch_key_on & ~key_cur;
  assign in_counter = cnt_q;
  assign env_out = env_out_q;
  assign env_slot = env_slot_q;
  assign env_valid = env_valid_q;
  assign phase_rst_out = phase_rst_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_idx_q <= 5'd0;
      cnt_q <= 16'd0;
      env_out_q <= 7'h7F;
      env_slot_q <= 5'd0;
      env_valid_q <= 1'b0;
      phase_rst_q <= 1'b0;
      key_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        env_q[i] <= 7'h7F;
        eg_q[i] <= 2'b00;
      end
    end else begin
      slot_idx_q <= slot_idx_d;
      cnt_q <= cnt_d;
      env_valid_q <= slot_en;
      if (slot_en) begin
        env_out_q <= env_next;
        env_slot_q <= slot_idx_q;
        phase_rst_q <= op_phase_reset;
      end
      for (int i = 0; i < NUM_SLOTS; i++)
        if (slot_en && slot_idx_q == 5'(i)) begin
          env_q[i] <= env_next;
          eg_q[i] <= eg_state_next;
          key_q[i] <= ch_key_on;
        end
    end
endmodule

// File: tb/tb_ym2413_env_seq.sv
// tb_ym2413_env_seq: directed scoreboard bench for ym2413_env_seq
module tb_ym2413_env_seq;
  logic clk = 1'b0;
  logic rst_n, slot_en, ch_key_on, op_phase_reset;
  logic [6:0] env_next;
  logic [1:0] eg_state_next;
  logic [3:0] ch_sel;
  logic op_type, key_off_on_trig, env_valid, phase_rst_out;
  logic [6:0] env_prev, env_out;
  logic [1:0] eg_state_prev;
  logic [15:0] in_counter;
  logic [4:0] env_slot;

  logic slot_en1;
  logic [3:0] ch_sel1;
  logic op_type1, trig1, valid1, prs1;
  logic [6:0] env_prev1, env_out1;
  logic [1:0] eg_prev1;
  logic [15:0] cnt1;
  logic [4:0] slot1;

  int errors = 0, checks = 0, cyc = 0, vcount = 0;

  typedef struct {
    int tag;
    logic [4:0] slot;
    logic [6:0] env;
    logic prs;
  } exp_t;
  exp_t q[$];

  int m_idx;
  logic [15:0] m_cnt;
  logic [6:0] m_env [18];
  logic [1:0] m_eg [18];
  logic m_key [18];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ym2413_env_seq dut (
    .clk(clk), .rst_n(rst_n), .slot_en(slot_en), .ch_key_on(ch_key_on),
    .env_next(env_next), .eg_state_next(eg_state_next), .op_phase_reset(op_phase_reset),
    .ch_sel(ch_sel), .op_type(op_type), .env_prev(env_prev), .eg_state_prev(eg_state_prev),
    .in_counter(in_counter), .key_off_on_trig(key_off_on_trig), .env_out(env_out),
    .env_slot(env_slot), .env_valid(env_valid), .phase_rst_out(phase_rst_out)
  );

  ym2413_env_seq #(.NUM_SLOTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .slot_en(slot_en1), .ch_key_on(1'b0),
    .env_next(7'h00), .eg_state_next(2'b00), .op_phase_reset(1'b0),
    .ch_sel(ch_sel1), .op_type(op_type1), .env_prev(env_prev1), .eg_state_prev(eg_prev1),
    .in_counter(cnt1), .key_off_on_trig(trig1), .env_out(env_out1),
    .env_slot(slot1), .env_valid(valid1), .phase_rst_out(prs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_cnt = 16'd0;
    for (int i = 0; i < 18; i++) begin
      m_env[i] = 7'h7F;
      m_eg[i] = 2'b00;
      m_key[i] = 1'b0;
    end
  endtask

  // drive one cycle of inputs, check the combinational view, and book the expected result
  task automatic step(input logic en, input logic [6:0] e, input logic [1:0] st, input logic p, input logic k);
    @(posedge clk);
    #1;
    slot_en = en;
    env_next = e;
    eg_state_next = st;
    op_phase_reset = p;
    ch_key_on = k;
    #1;
    chk("ch_sel", 32'(ch_sel), 32'(m_idx / 2));
    chk("op_type", 32'(op_type), 32'(m_idx % 2));
    chk("env_prev", 32'(env_prev), 32'(m_env[m_idx]));
    chk("eg_state_prev", 32'(eg_state_prev), 32'(m_eg[m_idx]));
    chk("key_trig", 32'(key_off_on_trig), 32'(k & ~m_key[m_idx]));
    chk("in_counter", 32'(in_counter), 32'(m_cnt));
    if (en) begin
      q.push_back('{tag: cyc, slot: 5'(m_idx), env: e, prs: p});
      m_env[m_idx] = e;
      m_eg[m_idx] = st;
      m_key[m_idx] = k;
      if (m_idx == 17) begin
        m_idx = 0;
        m_cnt = m_cnt + 16'd1;
      end else m_idx++;
    end
  endtask

  task automatic rnd_step(input logic k);
    step(1'b1, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), k);
  endtask

  always @(negedge clk) begin
    bit ev;
    exp_t it;
    ev = q.size() > 0 && q[0].tag == cyc - 1;
    chk("env_valid", 32'(env_valid), 32'(ev));
    if (ev) begin
      it = q.pop_front();
      chk("env_slot", 32'(env_slot), 32'(it.slot));
      chk("env_out", 32'(env_out), 32'(it.env));
      chk("phase_rst_out", 32'(phase_rst_out), 32'(it.prs));
    end
    if (env_valid) vcount++;
  end

  initial begin
    rst_n = 1'b0;
    slot_en = 1'b0;
    slot_en1 = 1'b0;
    ch_key_on = 1'b0;
    op_phase_reset = 1'b0;
    env_next = 7'h00;
    eg_state_next = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    slot_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_env_out", 32'(env_out), 32'h7F);
    chk("rst_env_slot", 32'(env_slot), 32'h0);
    chk("rst_env_valid", 32'(env_valid), 32'h0);
    chk("rst_phase_rst", 32'(phase_rst_out), 32'h0);
    chk("rst_counter", 32'(in_counter), 32'h0);
    chk("rst_env_prev", 32'(env_prev), 32'h7F);
    chk("rst_eg_prev", 32'(eg_state_prev), 32'h0);
    slot_en = 1'b0;
    rst_n = 1'b1;
    for (int s = 0; s < 18; s++) step(1'b1, 7'h7F, 2'b00, 1'b0, 1'b0);
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    chk("counter_after_period", 32'(in_counter), 32'h1);
    for (int s = 0; s < 18; s++) begin
      if (s == 5) begin
        step(1'b1, 7'h22, 2'b10, 1'b1, 1'b0);
        step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
        chk("slot5_valid", 32'(env_valid), 32'h1);
        chk("slot5_env_slot", 32'(env_slot), 32'h5);
        chk("slot5_env_out", 32'(env_out), 32'h22);
        chk("slot5_phase_rst", 32'(phase_rst_out), 32'h1);
      end else if (s == 3) begin
        step(1'b1, 7'h40, 2'b01, 1'b0, 1'b1);
        chk("slot3_first_trig", 32'(key_off_on_trig), 32'h1);
      end else rnd_step(1'b0);
    end
    for (int s = 0; s < 18; s++) begin
      if (s == 3) begin
        rnd_step(1'b1);
        chk("slot3_second_trig", 32'(key_off_on_trig), 32'h0);
        chk("slot3_eg_prev", 32'(eg_state_prev), 32'h1);
      end else if (s == 5) begin
        rnd_step(1'b0);
        chk("slot5_env_prev", 32'(env_prev), 32'h22);
      end else rnd_step(1'($urandom_range(0, 1)));
    end
    for (int s = 0; s < 18; s++) rnd_step(s == 3 ? 1'b0 : 1'($urandom_range(0, 1)));
    for (int s = 0; s < 18; s++) begin
      rnd_step(s == 3 ? 1'b1 : 1'($urandom_range(0, 1)));
      if (s == 3) chk("slot3_retrig", 32'(key_off_on_trig), 32'h1);
    end
    for (int s = 0; s < 18; s++) begin
      rnd_step(s == 3 ? 1'b1 : (s % 2 == 0));
      if (s == 3) chk("slot3_no_toggle_trig", 32'(key_off_on_trig), 32'h0);
    end
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    vcount = 0;
    for (int s = 0; s < 40; s++) rnd_step(1'($urandom_range(0, 1)));
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    chk("burst_valid_count", 32'(vcount), 32'd40);
    while (m_idx != 9) rnd_step(1'b1);
    @(posedge clk);
    #1;
    slot_en = 1'b1;
    env_next = 7'h11;
    eg_state_next = 2'b10;
    ch_key_on = 1'b1;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("midrst_valid", 32'(env_valid), 32'h0);
    chk("midrst_counter", 32'(in_counter), 32'h0);
    chk("midrst_ch_sel", 32'(ch_sel), 32'h0);
    @(posedge clk);
    #1;
    slot_en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst_valid_after", 32'(env_valid), 32'h0);
    for (int s = 0; s < 9; s++) rnd_step(1'b0);
    step(1'b1, 7'h30, 2'b11, 1'b0, 1'b1);
    chk("slot9_env_after_rst", 32'(env_prev), 32'h7F);
    chk("slot9_eg_after_rst", 32'(eg_state_prev), 32'h0);
    chk("slot9_trig_after_rst", 32'(key_off_on_trig), 32'h1);
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 7'h00, 2'b00, 1'b0, 1'b0);
    chk("wrap_start", 32'(cnt1), 32'h0);
    @(posedge clk);
    #1;
    slot_en1 = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    slot_en1 = 1'b0;
    chk("counter_ffff", 32'(cnt1), 32'hFFFF);
    @(posedge clk);
    #1;
    slot_en1 = 1'b1;
    @(posedge clk);
    #1;
    slot_en1 = 1'b0;
    chk("counter_wrap_0", 32'(cnt1), 32'h0);
    chk("single_slot_idx", 32'(ch_sel1), 32'h0);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
